pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator: samples an external PWM waveform and measures its period and high time in clk cycles.
- Publishes each completed measurement with a one-cycle valid strobe.
- Flags a stuck line (0 % / 100 % duty, or a disconnected input) through a timeout.
- Sits at the chip boundary in front of motor/servo feedback logic; also serves as the loop-back checker for the PWM generator.

Parameters:
- CNT_BITS, 16, width of the period/high-time counters and result registers; the maximum measurable period is 2^CNT_BITS-2 cycles.
- SYNC_STAGES, 2, number of synchroniser flops on pwm_in; legal range 2..4.
- FILT_LEN, 3, number of consecutive equal samples needed to change the filtered level (used only with PWM_GLITCH_FILTER_EN); legal range 2..15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  capture enable; low forces IDLE.
- pwm_in  in  1  asynchronous PWM input.
- period  out  CNT_BITS  cycles from one rising edge to the next, for the last complete cycle.
- high_time  out  CNT_BITS  cycles pwm was high within that same period.
- meas_valid  out  1  one-cycle strobe; period and high_time were updated this cycle.
- timeout  out  1  level; no rising edge seen for 2^CNT_BITS-1 cycles.
- stuck_level  out  1  synchronised pwm level latched when timeout set.

Behaviour:
- Reset:
  - Synchroniser flops = 0.
  - period = 0, high_time = 0, meas_valid = 0, timeout = 0, stuck_level = 0.
  - Internal counters = 0; state = IDLE.
- Synchroniser:
  - SYNC_STAGES flops; s = last stage.
  - rise = s & ~s_d, fall = ~s & s_d, where s_d is s delayed one cycle (reset 0).
  - pwm_in to rise latency = SYNC_STAGES+1 cycles.
- FSM states:
  - IDLE: counters held at 0. On rise with en=1, go to HIGH; pcnt = 1, hcnt = 1. A partial first cycle is never reported.
  - HIGH: pcnt++ and hcnt++ each cycle. On fall, go to LOW; hcnt holds.
  - LOW: pcnt++ each cycle. On rise, period <= pcnt, high_time <= hcnt, meas_valid = 1 for that cycle, timeout <= 0; then go to HIGH with pcnt = 1, hcnt = 1.
- Counter semantics: a waveform with H cycles high and L cycles low reports period = H+L and high_time = H. Minimum legal pattern is H = 1, L = 1, reporting 2 and 1.
- Timeout:
  - Condition: pcnt reaches 2^CNT_BITS-1 in HIGH or LOW.
  - Action: timeout <= 1, stuck_level <= s, state to IDLE, no meas_valid.
  - period and high_time keep their last values.
  - timeout stays high until the next meas_valid (which clears it) or reset.
  - pcnt never wraps.
- en deassert:
  - Any state goes to IDLE next cycle; counters cleared.
  - No strobe; outputs hold; timeout holds.
  - Re-enabling waits for a fresh rise.
- Simultaneous rise and timeout in the same cycle: the rise wins (measurement reported, timeout not set).
- Reset mid-measurement: all registers return to reset values on the next edge; an in-flight period is discarded.
- meas_valid is never high on two consecutive cycles; the minimum spacing is 2 cycles.

Optional Feature:
- Macro: PWM_GLITCH_FILTER_EN.
- Defined:
  - A FILT_LEN-deep agreement filter follows the synchroniser.
  - The filtered level f changes only after FILT_LEN consecutive identical samples of s.
  - rise/fall derive from f; latency grows by FILT_LEN cycles.
  - Pulses shorter than FILT_LEN cycles are ignored and folded into the surrounding level.
  - Filter state resets to 0.
- Undefined: f = s; no extra latency or logic.

Test Plan:
- Reset, en=1, pwm_in 5 high / 15 low repeating: first strobe follows the second rise, period=20, high_time=5; a strobe every 20 cycles thereafter.
- Pattern 1 high / 1 low: meas_valid every 2 cycles with period=2, high_time=1; never on consecutive cycles.
- CNT_BITS=8, pwm_in held high after one rise: timeout=1 and stuck_level=1 exactly 255 cycles after that rise's counter start; no strobe. A subsequent 10/10 waveform gives period=20 and clears timeout on its strobe.
- en dropped mid-HIGH for 3 cycles, then raised: no strobe from the broken cycle; the first strobe after the second post-enable rise has the exact period.
- reset asserted one cycle before an expected strobe: no strobe; all outputs 0 the next cycle.
- PWM_GLITCH_FILTER_EN, FILT_LEN=3, 40/40 waveform with a 2-cycle low glitch mid-high: period=80, high_time=40, no extra strobe. Without the macro, the same stimulus produces an extra measurement.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input in clk cycles.
// Optional glitch filter after the synchroniser is enabled by defining PWM_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int CNT_BITS    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                pwm_in,
    output logic [CNT_BITS-1:0] period,
    output logic [CNT_BITS-1:0] high_time,
    output logic                meas_valid,
    output logic                timeout,
    output logic                stuck_level
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_LEN < 2 || FILT_LEN > 15) begin : g_param_check
        $error("pwm_capture: SYNC_STAGES must be 2..4 and FILT_LEN 2..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    // Last count before the counter would reach all-ones; reaching it without a rise is a timeout.
    localparam logic [CNT_BITS-1:0] CNT_LAST = {{(CNT_BITS-1){1'b1}}, 1'b0};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic                   w_lvl;
    logic                   r_lvl_d;
    logic                   w_rise;
    logic                   w_fall;
    state_t                 r_state;
    logic [CNT_BITS-1:0]    r_pcnt;
    logic [CNT_BITS-1:0]    r_hcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

`ifdef PWM_GLITCH_FILTER_EN
    logic [FILT_LEN-2:0] r_filt_hist;
    logic [FILT_LEN-1:0] w_filt_win;
    logic                r_filt;

    assign w_filt_win = {r_filt_hist, w_s};

    // Level only moves once FILT_LEN consecutive samples agree; shorter pulses are absorbed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_hist <= '0;
            r_filt      <= 1'b0;
        end else begin
            r_filt_hist <= w_filt_win[FILT_LEN-2:0];
            if (&w_filt_win) begin
                r_filt <= 1'b1;
            end else if (~|w_filt_win) begin
                r_filt <= 1'b0;
            end
        end
    end

    assign w_lvl = r_filt;
`else
    assign w_lvl = w_s;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lvl_d <= 1'b0;
        end else begin
            r_lvl_d <= w_lvl;
        end
    end

    assign w_rise = w_lvl & ~r_lvl_d;
    assign w_fall = ~w_lvl & r_lvl_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pcnt      <= '0;
            r_hcnt      <= '0;
            period      <= '0;
            high_time   <= '0;
            meas_valid  <= 1'b0;
            timeout     <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                r_state <= ST_IDLE;
                r_pcnt  <= '0;
                r_hcnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            r_state <= ST_HIGH;
                            r_pcnt  <= CNT_ONE;
                            r_hcnt  <= CNT_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (r_pcnt == CNT_LAST) begin
                            timeout     <= 1'b1;
                            stuck_level <= w_lvl;
                            r_state     <= ST_IDLE;
                            r_pcnt      <= '0;
                            r_hcnt      <= '0;
                        end else begin
                            r_pcnt <= r_pcnt + CNT_ONE;
                            if (w_fall) begin
                                r_state <= ST_LOW;
                            end else begin
                                r_hcnt <= r_hcnt + CNT_ONE;
                            end
                        end
                    end
                    ST_LOW: begin
                        // A rise on the final count still closes the period rather than timing out.
                        if (w_rise) begin
                            period     <= r_pcnt;
                            high_time  <= r_hcnt;
                            meas_valid <= 1'b1;
                            timeout    <= 1'b0;
                            r_state    <= ST_HIGH;
                            r_pcnt     <= CNT_ONE;
                            r_hcnt     <= CNT_ONE;
                        end else if (r_pcnt == CNT_LAST) begin
                            timeout     <= 1'b1;
                            stuck_level <= w_lvl;
                            r_state     <= ST_IDLE;
                            r_pcnt      <= '0;
                            r_hcnt      <= '0;
                        end else begin
                            r_pcnt <= r_pcnt + CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_pcnt  <= '0;
                        r_hcnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
